// File: rtl/bf_bus_bridge.sv
// Off-chip bridge for the BF tapeout bus: decodes the serialized opcode/address/data
// phases from the chip and services them against memory or host byte streams.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for an Opcode phase from the chip
// S_ADDR_HI | opcode latched, waiting for AddrHi
// S_ADDR_LO | high address latched, waiting for AddrLo
// S_DATA    | full address latched, waiting for the first ReadWrite cycle
// S_EXEC    | performing the memory / stream operation
// S_DONE    | presenting op_done and result until the chip is enabled
module bf_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  chip_bus,
  input  logic [2:0]  chip_state,
  input  logic        chip_halted,
  output logic [7:0]  chip_data,
  output logic        chip_op_done,
  output logic        chip_enable,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_space,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        halted,
  output logic        proto_err,
  output logic        timeout_err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR_HI = 3'd1;
  localparam logic [2:0] S_ADDR_LO = 3'd2;
  localparam logic [2:0] S_DATA    = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [2:0] CS_NONE    = 3'd0;
  localparam logic [2:0] CS_OPCODE  = 3'd1;
  localparam logic [2:0] CS_ADDR_HI = 3'd2;
  localparam logic [2:0] CS_ADDR_LO = 3'd3;
  localparam logic [2:0] CS_RW      = 3'd4;

  localparam logic [2:0] OP_MEM_RD  = 3'd1;
  localparam logic [2:0] OP_MEM_WR  = 3'd2;
  localparam logic [2:0] OP_PROG_RD = 3'd3;
  localparam logic [2:0] OP_IN      = 3'd4;
  localparam logic [2:0] OP_OUT     = 3'd5;

  logic [2:0]    state;
  logic [2:0]    opc;
  logic [14:0]   addr;
  logic [7:0]    wdata;
  logic [7:0]    result;
  logic [TW-1:0] tcnt;
  logic          is_mem;
  logic          is_illegal;
  logic          in_exec;
  logic          tmo_hit;

  assign is_mem     = (opc == OP_MEM_RD) || (opc == OP_MEM_WR) || (opc == OP_PROG_RD);
  assign is_illegal = (opc[2:1] == 2'b11);
  assign in_exec    = (state == S_EXEC);
  // Down-counter loaded with TIMEOUT on EXEC entry; terminal count at 1 gives TIMEOUT wait cycles.
  assign tmo_hit    = (TIMEOUT != 0) && (tcnt == TW'(1));

  assign chip_enable  = run;
  assign chip_op_done = (state == S_DONE);
  assign chip_data    = chip_op_done ? result : 8'h00;
  assign mem_req      = in_exec && is_mem;
  assign mem_we       = mem_req && (opc == OP_MEM_WR);
  assign mem_space    = mem_req && (opc == OP_PROG_RD);
  assign mem_addr     = addr;
  assign mem_wdata    = mem_we ? wdata : 8'h00;
  assign in_ready     = in_exec && (opc == OP_IN);
  assign out_valid    = in_exec && (opc == OP_OUT);
  assign out_data     = out_valid ? wdata : 8'h00;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      opc         <= 3'd0;
      addr        <= 15'd0;
      wdata       <= 8'h00;
      result      <= 8'h00;
      tcnt        <= '0;
      halted      <= 1'b0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      halted <= chip_halted;
      case (state)
        S_IDLE: begin
          if (run && chip_state == CS_OPCODE) begin
            opc   <= chip_bus[2:0];
            state <= S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          if (run) begin
            if (chip_state == CS_OPCODE) begin
              opc <= chip_bus[2:0];
            end else if (chip_state == CS_ADDR_HI) begin
              addr[14:8] <= chip_bus[6:0];
              state      <= S_ADDR_LO;
            end else begin
              proto_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_ADDR_LO: begin
          if (run) begin
            if (chip_state == CS_OPCODE) begin
              opc   <= chip_bus[2:0];
              state <= S_ADDR_HI;
            end else if (chip_state == CS_ADDR_LO) begin
              addr[7:0] <= chip_bus;
              state     <= S_DATA;
            end else if (chip_state != CS_ADDR_HI) begin
              proto_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (run) begin
            if (chip_state == CS_OPCODE) begin
              opc   <= chip_bus[2:0];
              state <= S_ADDR_HI;
            end else if (chip_state == CS_RW) begin
              wdata <= chip_bus;
              tcnt  <= TW'(TIMEOUT);
              state <= S_EXEC;
            end else if (chip_state != CS_ADDR_LO) begin
              proto_err <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        S_EXEC: begin
          if (run && chip_state == CS_NONE) begin
            proto_err <= 1'b1;
            state     <= S_IDLE;
          end else if (is_illegal) begin
            result    <= 8'h00;
            proto_err <= 1'b1;
            state     <= S_DONE;
          end else if (is_mem) begin
            // An acknowledge on the terminal-count edge still completes normally.
            if (mem_ack) begin
              result <= (opc == OP_MEM_WR) ? 8'h00 : mem_rdata;
              state  <= S_DONE;
            end else if (tmo_hit) begin
              result      <= 8'hFF;
              timeout_err <= 1'b1;
              state       <= S_DONE;
            end else begin
              tcnt <= tcnt - TW'(1);
            end
          end else if (opc == OP_IN) begin
            if (in_valid) begin
              result <= in_data;
              state  <= S_DONE;
            end
          end else if (opc == OP_OUT) begin
            if (out_ready) begin
              result <= 8'h00;
              state  <= S_DONE;
            end
          end else begin
            result <= 8'h00;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (run) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
